// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: seven-segment display controller for the board test top.
//
// Drives DIGITS active-low hex digits from a switch word. A bouncy
// active-low pushbutton is synchronized and debounced; each accepted press
// captures the switch word into a hold register. The display shows the live
// word, the held word, the held word rotated (scroll), or the held word with
// leading zeros blanked.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   data_in     in   switch word, nibble i drives digit i
//   load_n      in   raw active-low pushbutton
//   mode        in   00 live, 01 hold, 10 scroll, 11 hold + zero blanking
//   seg_out     out  active-low segments, digit i at [7i+6:7i], bit 7i = a
//   held_value  out  captured word
//   load_pulse  out  one-cycle strobe per accepted press

// Per-digit glyph decode. Output is {g,f,e,d,c,b,a}, active low.
module hex_seg_lane (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            case (nib)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                default: seg = 7'h0E;
            endcase
        end
    end
endmodule

module hex_disp_ctrl #(
    parameter int DIGITS        = 8,
    parameter int DB_CYCLES     = 500000,
    parameter int SCROLL_CYCLES = 12500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  load_n,
    input  logic [1:0]            mode,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic [4*DIGITS-1:0]   held_value,
    output logic                  load_pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int PW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam int OW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCROLL_CYCLES - 1);
    localparam logic [OW-1:0] OFF_MAX = OW'(DIGITS - 1);

    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 db_q, db_d, db_prev_q, db_prev_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  held_q, held_d;
    logic                 pulse_q, pulse_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [OW-1:0]        off_q, off_d;
    logic [7*DIGITS-1:0]  seg_q, seg_d;

    logic [DIGITS-1:0][3:0] data_nib, held_nib, nib_sel;
    logic [DIGITS-1:0]      blank;
    logic                   any_nz;
    int                     rot_idx;

    assign data_nib = data_in;
    assign held_nib = held_q;

    // Sync, debounce, press detect and scroll counters.
    always_comb begin
        sync1_d   = load_n;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        db_prev_d = db_q;
        // Press is the 1->0 transition of the debounced level, seen one
        // edge after db falls; the release edge is ignored.
        pulse_d   = db_prev_q & ~db_q;
        held_d    = pulse_d ? data_in : held_q;

        pre_d = '0;
        off_d = '0;
        if (mode == 2'b10) begin
            off_d = off_q;
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                off_d = (off_q == OFF_MAX) ? '0 : off_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Source nibble and blanking per digit. Walking from the top digit
    // down, a digit is blanked while no non-zero nibble has been seen yet;
    // digit 0 always shows.
    always_comb begin
        nib_sel = '0;
        blank   = '0;
        any_nz  = 1'b0;
        rot_idx = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            rot_idx = i + int'(off_q);
            if (rot_idx >= DIGITS) rot_idx = rot_idx - DIGITS;
            any_nz = any_nz | (held_nib[i] != 4'h0);
            case (mode)
                2'b00:   nib_sel[i] = data_nib[i];
                2'b10:   nib_sel[i] = held_nib[rot_idx];
                default: nib_sel[i] = held_nib[i];
            endcase
            blank[i] = (mode == 2'b11) && !any_nz && (i != 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_lane
        hex_seg_lane u_lane (
            .nib   (nib_sel[g]),
            .blank (blank[g]),
            .seg   (seg_d[g*7 +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            cnt_q     <= '0;
            held_q    <= '0;
            pulse_q   <= 1'b0;
            pre_q     <= '0;
            off_q     <= '0;
            seg_q     <= '1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            pulse_q   <= pulse_d;
            pre_q     <= pre_d;
            off_q     <= off_d;
            seg_q     <= seg_d;
        end
    end

    assign seg_out    = seg_q;
    assign held_value = held_q;
    assign load_pulse = pulse_q;
endmodule

// File: tb/tb_hex_disp_ctrl.sv
module tb_hex_disp_ctrl;
    localparam int D  = 4;
    localparam int DB = 4;
    localparam int SC = 3;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N;
    logic [15:0]   data_in;
    logic          load_n;
    logic [1:0]    mode;
    logic [27:0]   seg_out;
    logic [15:0]   held_value;
    logic          load_pulse;

    hex_disp_ctrl #(.DIGITS(D), .DB_CYCLES(DB), .SCROLL_CYCLES(SC)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .data_in    (data_in),
        .load_n     (load_n),
        .mode       (mode),
        .seg_out    (seg_out),
        .held_value (held_value),
        .load_pulse (load_pulse)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lit segments of each hex glyph.
    function automatic string lit_segs(input logic [3:0] n);
        case (n)
            4'h0: return "abcdef";  4'h1: return "bc";
            4'h2: return "abdeg";   4'h3: return "abcdg";
            4'h4: return "bcfg";    4'h5: return "acdfg";
            4'h6: return "acdefg";  4'h7: return "abc";
            4'h8: return "abcdefg"; 4'h9: return "abcdfg";
            4'hA: return "abcefg";  4'hB: return "cdefg";
            4'hC: return "adef";    4'hD: return "bcdeg";
            4'hE: return "adefg";   default: return "aefg";
        endcase
    endfunction

    // Active-low 7-bit value, bit 0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        string s;
        logic [6:0] r;
        s = lit_segs(n);
        r = 7'h7F;
        for (int k = 0; k < s.len(); k++) r[int'(s[k]) - 97] = 1'b0;
        return r;
    endfunction

    // Literal written as levels of a..g in that order.
    function automatic logic [6:0] ag(input string s);
        logic [6:0] r;
        for (int k = 0; k < 7; k++) r[k] = (s[k] == 8'h31);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    bit          mq[$];
    bit          m_db;
    int          m_run;
    bit          m_fell;
    bit          m_pulse;
    logic [15:0] m_held;
    logic [27:0] m_seg;
    int          m_ticks;

    function automatic logic [27:0] display(input logic [1:0] md, input logic [15:0] live,
                                            input logic [15:0] hv, input int ticks);
        logic [27:0] r;
        int off, msb, src;
        off = (ticks / SC) % D;
        msb = 0;
        for (int i = 0; i < D; i++) if (hv[4*i +: 4] != 4'h0) msb = i;
        for (int i = 0; i < D; i++) begin
            src = (md == 2'b10) ? (i + off) % D : i;
            r[7*i +: 7] = glyph((md == 2'b00) ? live[4*i +: 4] : hv[4*src +: 4]);
            if (md == 2'b11 && i > msb) r[7*i +: 7] = 7'h7F;
        end
        return r;
    endfunction

    task automatic model_reset();
        mq = '{1'b1, 1'b1};
        m_db = 1'b1; m_run = 0; m_fell = 1'b0; m_pulse = 1'b0;
        m_held = '0; m_seg = '1; m_ticks = 0;
    endtask

    task automatic model_step();
        bit seen;
        if (!RESET_N) begin
            model_reset();
        end else begin
            m_seg = display(mode, data_in, m_held, m_ticks);
            m_pulse = m_fell;
            if (m_fell) m_held = data_in;
            // The button level becomes visible two edges after sampling.
            seen = mq[0];
            mq.pop_front();
            mq.push_back(load_n);
            m_fell = 1'b0;
            if (seen != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_fell = m_db;
                    m_db   = seen;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_ticks = (mode == 2'b10) ? m_ticks + 1 : 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLOCK_50 or negedge RESET_N);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (cmp_on) begin
                chk("seg_out", {4'h0, seg_out}, {4'h0, m_seg});
                chk("held_value", {16'h0, held_value}, {16'h0, m_held});
                chk("load_pulse", {31'h0, load_pulse}, {31'h0, m_pulse});
                if (load_pulse) pulse_cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input logic [15:0] v);
        data_in = v;
        load_n = 1'b0;
        cyc(10);
        load_n = 1'b1;
        cyc(12);
    endtask

    int p0;
    logic [6:0] scr_exp [4];

    initial begin
        RESET_N = 1'b0; load_n = 1'b1; mode = 2'b00; data_in = '0;
        @(posedge CLOCK_50);
        cmp_on = 1'b1;
        cyc(3);
        RESET_N = 1'b1;
        cyc(2);

        // Zero held value with blanking: single "0" on digit 0.
        mode = 2'b11;
        cyc(1);
        chk("zero_blank", {4'h0, seg_out}, {4'h0, 7'h7F, 7'h7F, 7'h7F, ag("0000001")});

        // Live glyphs.
        mode = 2'b00; data_in = 16'h1A0F;
        cyc(1);
        chk("live_1A0F", {4'h0, seg_out},
            {4'h0, ag("1001111"), ag("0001000"), ag("0000001"), ag("0111000")});

        // Clean press.
        p0 = pulse_cnt;
        press(16'h00B3);
        chk("press_pulses", pulse_cnt - p0, 1);
        chk("press_held", {16'h0, held_value}, 32'h00B3);
        mode = 2'b11;
        cyc(1);
        chk("blank_00B3", {4'h0, seg_out},
            {4'h0, 7'h7F, 7'h7F, ag("1100000"), ag("0000110")});

        // Bounce: runs of two samples never reach the window.
        p0 = pulse_cnt;
        for (int r = 0; r < 5; r++) begin
            load_n = 1'b0; cyc(2);
            load_n = 1'b1; cyc(2);
        end
        cyc(8);
        chk("bounce_pulses", pulse_cnt - p0, 0);
        chk("bounce_held", {16'h0, held_value}, 32'h00B3);

        // Reset in the middle of a real press.
        load_n = 1'b0;
        cyc(4);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_seg", {4'h0, seg_out}, 32'h0FFFFFFF);
        chk("rst_held", {16'h0, held_value}, 32'h0);
        chk("rst_pulse", {31'h0, load_pulse}, 32'h0);
        load_n = 1'b1;
        cyc(1);
        RESET_N = 1'b1;
        p0 = pulse_cnt;
        cyc(12);
        chk("rst_no_pulse", pulse_cnt - p0, 0);

        // Scroll of 4321.
        mode = 2'b01;
        press(16'h4321);
        chk("scroll_held", {16'h0, held_value}, 32'h4321);
        scr_exp[0] = ag("1001111"); scr_exp[1] = ag("0010010");
        scr_exp[2] = ag("0000110"); scr_exp[3] = ag("1001100");
        mode = 2'b10;
        cyc(1);
        chk("scroll_0", {25'h0, seg_out[6:0]}, {25'h0, scr_exp[0]});
        for (int k = 1; k <= 4; k++) begin
            cyc(3);
            chk($sformatf("scroll_%0d", k), {25'h0, seg_out[6:0]}, {25'h0, scr_exp[k % 4]});
        end
        mode = 2'b01;
        cyc(1);
        mode = 2'b10;
        cyc(1);
        chk("scroll_reenter", {25'h0, seg_out[6:0]}, {25'h0, scr_exp[0]});

        // Random traffic against the model.
        for (int it = 0; it < 120; it++) begin
            mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    data_in = 16'($urandom);
                    load_n = 1'b0;
                    cyc($urandom_range(5, 9));
                    load_n = 1'b1;
                    cyc($urandom_range(6, 10));
                end
                1: begin
                    load_n = 1'b0;
                    cyc($urandom_range(1, 3));
                    load_n = 1'b1;
                    cyc($urandom_range(1, 4));
                end
                default: begin
                    repeat ($urandom_range(1, 8)) begin
                        data_in = 16'($urandom);
                        cyc(1);
                    end
                end
            endcase
        end
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
